// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
//   Groups the byte stream from the PS/2 controller and the key outputs into one bundle.
//   slave  : decoder side (consumes bytes and event_ready, drives key state and events)
//   master : producer/consumer side (drives bytes and event_ready, observes key state)
//   Signals:
//     ps2_byte[7:0]        received byte
//     ps2_byte_valid       one-cycle strobe qualifying ps2_byte
//     key_held[6:0]        per-key held level
//     key_press_pulse[6:0] one-cycle pulse on a key's press
//     event_valid          event register holds an unconsumed event
//     event_ready          consumer accepts the event
//     event_key[2:0]       key index of the buffered event
//     event_press          1 = press, 0 = release
//     overflow             sticky, an event was dropped
interface ps2_key_decoder_if;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic [6:0] key_held;
    logic [6:0] key_press_pulse;
    logic       event_valid;
    logic       event_ready;
    logic [2:0] event_key;
    logic       event_press;
    logic       overflow;

    modport slave (
        input  ps2_byte, ps2_byte_valid, event_ready,
        output key_held, key_press_pulse, event_valid, event_key, event_press, overflow
    );

    modport master (
        output ps2_byte, ps2_byte_valid, event_ready,
        input  key_held, key_press_pulse, event_valid, event_key, event_press, overflow
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Decodes make / break / E0-extended scan-code sequences for seven keys into held
//   levels, press pulses and a single-entry key-event buffer. Typematic repeats are
//   filtered because a make of an already-held key does nothing.
//   Ports:
//     CLOCK_50  system clock, rising edge
//     reset     synchronous, active-high
//     bus       ps2_key_decoder_if.slave (byte stream in, key state and events out)
//   Key map: 0 Enter(5A) 1 Space(29) 2 Esc(76) 3 Up(E0 75) 4 Down(E0 72)
//            5 Left(E0 6B) 6 Right(E0 74)
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | no prefix seen; next code is a normal make
//   GOT_E0    | E0 seen; next code is an extended make
//   GOT_F0    | F0 seen; next code is a normal break
//   GOT_E0F0  | E0 and F0 seen; next code is an extended break
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned TIMEOUT_WIDTH  = 22
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    ps2_key_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [6:0]               held_q, held_d;
    logic [6:0]               pulse_q, pulse_d;
    logic                     ev_valid_q, ev_valid_d;
    logic [2:0]               ev_key_q, ev_key_d;
    logic                     ev_press_q, ev_press_d;
    logic                     ovf_q, ovf_d;

    logic       is_filler;
    logic       byte_act;
    logic       norm_hit, ext_hit, hit;
    logic [2:0] norm_idx, ext_idx, idx;
    logic       do_make, do_break, is_ext;
    logic       new_ev, new_press;

    // Filler bytes (controller acks, BAT results, etc.) are invisible to the
    // decoder: they neither advance the FSM nor restart the prefix timeout.
    always_comb begin
        is_filler = 1'b0;
        case (bus.ps2_byte)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_filler = 1'b1;
            default:                                  is_filler = 1'b0;
        endcase
    end

    assign byte_act = bus.ps2_byte_valid && !is_filler;

    always_comb begin
        norm_hit = 1'b0;
        norm_idx = 3'd0;
        case (bus.ps2_byte)
            8'h5A:   begin norm_hit = 1'b1; norm_idx = 3'd0; end
            8'h29:   begin norm_hit = 1'b1; norm_idx = 3'd1; end
            8'h76:   begin norm_hit = 1'b1; norm_idx = 3'd2; end
            default: begin norm_hit = 1'b0; norm_idx = 3'd0; end
        endcase
    end

    always_comb begin
        ext_hit = 1'b0;
        ext_idx = 3'd0;
        case (bus.ps2_byte)
            8'h75:   begin ext_hit = 1'b1; ext_idx = 3'd3; end
            8'h72:   begin ext_hit = 1'b1; ext_idx = 3'd4; end
            8'h6B:   begin ext_hit = 1'b1; ext_idx = 3'd5; end
            8'h74:   begin ext_hit = 1'b1; ext_idx = 3'd6; end
            default: begin ext_hit = 1'b0; ext_idx = 3'd0; end
        endcase
    end

    // Sequence FSM and prefix timeout. An accepted byte always wins over an
    // expiring timeout in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        is_ext   = 1'b0;
        if (byte_act) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (bus.ps2_byte == 8'hE0)      state_d = GOT_E0;
                    else if (bus.ps2_byte == 8'hF0) state_d = GOT_F0;
                    else                            do_make = 1'b1;
                end
                GOT_E0: begin
                    if (bus.ps2_byte == 8'hF0) begin
                        state_d = GOT_E0F0;
                    end else if (bus.ps2_byte != 8'hE0) begin
                        do_make = 1'b1;
                        is_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                GOT_F0: begin
                    if (bus.ps2_byte == 8'hE0) begin
                        state_d = GOT_E0F0;
                    end else if (bus.ps2_byte != 8'hF0) begin
                        do_break = 1'b1;
                        state_d  = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (bus.ps2_byte != 8'hE0 && bus.ps2_byte != 8'hF0) begin
                        do_break = 1'b1;
                        is_ext   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == TO_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // A code only counts if it belongs to the class selected by the prefix.
    assign hit = is_ext ? ext_hit : norm_hit;
    assign idx = is_ext ? ext_idx : norm_idx;

    always_comb begin
        held_d    = held_q;
        pulse_d   = '0;
        new_ev    = 1'b0;
        new_press = 1'b0;
        if (do_make && hit && !held_q[idx]) begin
            held_d[idx]  = 1'b1;
            pulse_d[idx] = 1'b1;
            new_ev       = 1'b1;
            new_press    = 1'b1;
        end else if (do_break && hit && held_q[idx]) begin
            held_d[idx] = 1'b0;
            new_ev      = 1'b1;
            new_press   = 1'b0;
        end
    end

    // Single-entry event buffer. A consume and a load in the same cycle
    // replace the entry without a bubble.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_key_d   = ev_key_q;
        ev_press_d = ev_press_q;
        ovf_d      = ovf_q;
        if (new_ev) begin
            if (!ev_valid_q || bus.event_ready) begin
                ev_valid_d = 1'b1;
                ev_key_d   = idx;
                ev_press_d = new_press;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (ev_valid_q && bus.event_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            held_q     <= '0;
            pulse_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_key_q   <= 3'd0;
            ev_press_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            pulse_q    <= pulse_d;
            ev_valid_q <= ev_valid_d;
            ev_key_q   <= ev_key_d;
            ev_press_q <= ev_press_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.key_held        = held_q;
    assign bus.key_press_pulse = pulse_q;
    assign bus.event_valid     = ev_valid_q;
    assign bus.event_key       = ev_key_q;
    assign bus.event_press     = ev_press_q;
    assign bus.overflow        = ovf_q;

endmodule
